// File: rtl/serial_word_receiver_if.sv
// Bus bundle for serial_word_receiver: serial line in, buffered word out.
// Handshake: data_out is a valid word while data_valid is high; the word is
// consumed on any rising clk edge where data_valid && data_ready; data_valid
// never drops without such an edge (except at reset), and data_out does not
// change while data_valid is high unless a new word lands on the consuming edge.
interface serial_word_receiver_if #(
  parameter int DATA_BITS = 4
);
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;
  logic [2:0]           dbg_state;

  // Receiver side
  modport slave (
    input  rx,
    input  data_ready,
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output dbg_state
  );

  // Line driver / word consumer side
  modport master (
    output rx,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  dbg_state
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel frame receiver: start bit, DATA_BITS data bits LSB first,
// stop bit. Completed words land in a one-entry buffer with valid/ready;
// framing errors and dropped words are reported as one-cycle pulses.
module serial_word_receiver #(
  parameter int DATA_BITS    = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input logic                  clk,
  input logic                  reset,
  serial_word_receiver_if.slave io_bus
);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rx_s;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_sh, w_sh_nxt, w_sh_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid, r_frame_err, r_overrun;
  logic                 w_deliver, w_stop_bad, w_take;

  // New bit enters at the top so the first-received bit ends up in bit 0.
  assign w_sh_shift = (r_sh >> 1) | (DATA_BITS'(r_rx_s) << (DATA_BITS - 1));

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= io_bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame FSM next state: bit timing, data shifting and stop-bit verdict.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_deliver   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt = '0;
          w_sh_nxt  = w_sh_shift;
          if (r_idx == IDX_LAST) w_state_nxt = S_STOP;
          else                   w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt   = '0;
          w_deliver   = r_rx_s;
          w_stop_bad  = !r_rx_s;
          w_state_nxt = r_rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // Line stuck low after a bad stop bit: wait for it to recover.
        w_cnt_nxt = '0;
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_sh    <= w_sh_nxt;
    end
  end

  // A delivered word is accepted if the buffer is empty or emptying this edge.
  assign w_take = w_deliver && (!r_data_valid || io_bus.data_ready);

  // Output buffer plus error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_deliver && !w_take;
      if (w_take) begin
        r_data_out   <= r_sh;
        r_data_valid <= 1'b1;
      end else if (r_data_valid && io_bus.data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign io_bus.data_out   = r_data_out;
  assign io_bus.data_valid = r_data_valid;
  assign io_bus.frame_err  = r_frame_err;
  assign io_bus.overrun    = r_overrun;
  assign io_bus.dbg_state  = r_state;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed scenarios then random frames,
// compared every cycle against a frame-level reference model.
module tb_serial_word_receiver;
  localparam int DATA_BITS    = 4;
  localparam int CLKS_PER_BIT = 16;
  localparam int H            = CLKS_PER_BIT / 2;
  // Edge (relative to the first edge that samples the start bit low)
  // at which the stop bit is judged and the buffer updates.
  localparam int STOP_OFF     = 2 + H + (DATA_BITS + 1) * CLKS_PER_BIT;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  serial_word_receiver_if #(.DATA_BITS(DATA_BITS)) bus ();

  serial_word_receiver #(
    .DATA_BITS   (DATA_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: frames in flight with their completion edge and stop verdict
  logic [DATA_BITS-1:0] exp_q[$];
  int                   exp_cyc_q[$];
  bit                   exp_ok_q[$];

  // Reference view of the outputs
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_fe;
  logic                 m_ov;

  int cyc;
  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Apply one rising edge to the reference model.
  task automatic model_step();
    logic [DATA_BITS-1:0] w;
    bit                   ok;
    bit                   loaded;
    m_fe   = 1'b0;
    m_ov   = 1'b0;
    loaded = 1'b0;
    if (reset) begin
      m_data  = '0;
      m_valid = 1'b0;
      exp_q.delete();
      exp_cyc_q.delete();
      exp_ok_q.delete();
    end else begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        void'(exp_cyc_q.pop_front());
        w  = exp_q.pop_front();
        ok = exp_ok_q.pop_front();
        if (!ok) begin
          m_fe = 1'b1;
        end else if (!m_valid || bus.data_ready) begin
          m_data  = w;
          m_valid = 1'b1;
          loaded  = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end
      if (!loaded && m_valid && bus.data_ready) m_valid = 1'b0;
    end
  endtask

  // One clock: update model on the edge, compare just after it.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("data_valid", 32'(bus.data_valid), 32'(m_valid));
    check("data_out",   32'(bus.data_out),   32'(m_data));
    check("frame_err",  32'(bus.frame_err),  32'(m_fe));
    check("overrun",    32'(bus.overrun),    32'(m_ov));
  endtask

  task automatic idle(input int n, input bit rnd_rdy);
    for (int i = 0; i < n; i++) begin
      bus.rx = 1'b1;
      if (rnd_rdy) bus.data_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx = 1'b0;
      tick();
    end
  endtask

  // rdy_mode: 0 leave data_ready alone, 1 random each cycle,
  // 2 high only on the stop-sample edge. rst_off >= 0 pulses reset at that
  // edge offset and abandons the frame.
  task automatic send_frame(input logic [DATA_BITS-1:0] word, input bit stop_ok,
                            input int rdy_mode, input int rst_off);
    int   e0;
    logic bitv;
    e0 = cyc + 1;
    if (rst_off < 0) begin
      exp_q.push_back(word);
      exp_cyc_q.push_back(e0 + STOP_OFF);
      exp_ok_q.push_back(stop_ok);
    end
    for (int b = 0; b < DATA_BITS + 2; b++) begin
      if (b == 0)              bitv = 1'b0;
      else if (b <= DATA_BITS) bitv = word[b-1];
      else                     bitv = stop_ok;
      for (int k = 0; k < CLKS_PER_BIT; k++) begin
        bus.rx = bitv;
        if (rdy_mode == 1)      bus.data_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 2) bus.data_ready = (cyc + 1 == e0 + STOP_OFF);
        if (rst_off >= 0 && cyc + 1 == e0 + rst_off) begin
          reset  = 1'b1;
          bus.rx = 1'b1;
          tick();
          reset  = 1'b0;
          check("midrst_valid", 32'(bus.data_valid), 32'd0);
          check("midrst_data",  32'(bus.data_out),   32'd0);
          check("midrst_fe",    32'(bus.frame_err),  32'd0);
          check("midrst_ov",    32'(bus.overrun),    32'd0);
          return;
        end
        tick();
      end
    end
  endtask

  // Directed sequence, then random traffic, then report.
  initial begin
    logic [DATA_BITS-1:0] word;
    bit                   ok;
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    bus.rx         = 1'b1;
    bus.data_ready = 1'b1;
    reset          = 1'b1;
    tick(); tick(); tick();
    check("reset_valid", 32'(bus.data_valid), 32'd0);
    check("reset_data",  32'(bus.data_out),   32'd0);
    reset = 1'b0;
    idle(5, 1'b0);

    // Basic frame 0xB with consumer always ready
    bus.data_ready = 1'b1;
    send_frame(4'hB, 1'b1, 0, -1);
    idle(10, 1'b0);

    // Short low glitch: must be ignored
    hold_low(4);
    idle(40, 1'b0);

    // Bad stop bit, line held low, then recovery and a good frame
    send_frame(4'hA, 1'b0, 0, -1);
    hold_low(24);
    idle(5, 1'b0);
    send_frame(4'hA, 1'b1, 0, -1);
    idle(10, 1'b0);

    // Overrun: two back-to-back frames with nobody consuming
    bus.data_ready = 1'b0;
    send_frame(4'h3, 1'b1, 0, -1);
    send_frame(4'h5, 1'b1, 0, -1);
    idle(5, 1'b0);
    check("overrun_hold", 32'(bus.data_out), 32'h3);
    bus.data_ready = 1'b1;
    idle(5, 1'b0);

    // Consume and deliver on the same edge
    bus.data_ready = 1'b0;
    send_frame(4'h3, 1'b1, 0, -1);
    idle(3, 1'b0);
    send_frame(4'hC, 1'b1, 2, -1);
    idle(5, 1'b0);
    check("same_edge_data", 32'(bus.data_out), 32'hC);

    // Reset in the middle of data bit 2, then a clean frame
    send_frame(4'h9, 1'b1, 0, 56);
    idle(10, 1'b0);
    bus.data_ready = 1'b1;
    send_frame(4'h6, 1'b1, 0, -1);
    idle(10, 1'b0);

    // Random traffic with random consumer and occasional bad stop bits
    for (int f = 0; f < 14; f++) begin
      word = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
      ok   = ($urandom_range(0, 5) != 0);
      send_frame(word, ok, 1, -1);
      if (!ok) begin
        hold_low($urandom_range(0, 30));
        idle(4 + $urandom_range(0, 8), 1'b1);
      end else begin
        idle($urandom_range(0, 12), 1'b1);
      end
    end
    bus.data_ready = 1'b1;
    idle(20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
